// File: rtl/alu_seq_unit.sv
// -----------------------------------------------------------------------------
// alu_seq_unit
//   Multi-cycle ALU with built-in ALU-control decode. Single-cycle ops
//   (ADD/SUB/AND/OR/SLL) finish one clock after the accept edge. MUL is a
//   shift-add loop of WIDTH steps. DIVU/REMU is a restoring divider of WIDTH
//   steps. Every request passes through FIN, which produces the done pulse.
//
//   Optional feature macro: ALU_SEQ_DIV_EN
//     defined   -> DIVU/REMU decode, DIV state and divider datapath are built
//     undefined -> mext divide encodings are illegal and complete in one
//                  cycle with result 0
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   start      request strobe, sampled only in IDLE
//   ALUOp[1:0] 00 I/load/store, 01 branch, 10 R-type, 11 reserved
//   Funct[3:0] {funct7[5], funct3}
//   mext       funct7[0], selects M-extension ops for R-type
//   a, b       operands, captured on the accept edge
//   busy       high from the accept edge until done rises
//   done       one-cycle result-valid pulse
//   result     result, held until the next done
//   zero       result == 0, registered with result
//   illegal    unsupported encoding, registered with done
//   Operation  decoded 4-bit op of the last accepted request
// -----------------------------------------------------------------------------
module alu_seq_unit #(
    parameter int WIDTH = 64,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       ALUOp,
    input  logic [3:0]       Funct,
    input  logic             mext,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal,
    output logic [3:0]       Operation
);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLL  = 4'b1000;
    localparam logic [3:0] OP_MUL  = 4'b1001;
`ifdef ALU_SEQ_DIV_EN
    localparam logic [3:0] OP_DIVU = 4'b1010;
    localparam logic [3:0] OP_REMU = 4'b1011;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
`ifdef ALU_SEQ_DIV_EN
        S_DIV  = 2'd2,
`endif
        S_FIN  = 2'd3
    } state_t;

    // Control / output registers (async reset)
    state_t           state_q, state_d;
    logic [3:0]       op_q, op_d;
    logic             ill_pend_q, ill_pend_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             illegal_q, illegal_d;

    // Datapath registers (no reset; always loaded on accept).
    // MUL: acc = partial product, mcand = shifted multiplicand, mplier = multiplier.
    // DIV: acc = partial remainder, mcand = divisor, mplier = dividend/quotient.
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [SHW:0]     cnt_q, cnt_d;

    logic [3:0]       dec_op;
    logic             dec_ill;
    logic             dec_clr;
    logic [WIDTH-1:0] alu_val;
    logic [WIDTH-1:0] fin_val;

    // ---------------- decode ----------------
    always_comb begin
        dec_op  = OP_ADD;
        dec_ill = 1'b0;
        dec_clr = 1'b0;
        case (ALUOp)
            2'b00: dec_op = (Funct[2:0] == 3'b001) ? OP_SLL : OP_ADD;
            2'b01: dec_op = OP_SUB;
            2'b10: begin
                if (!mext) begin
                    case (Funct)
                        4'b0000: dec_op = OP_ADD;
                        4'b1000: dec_op = OP_SUB;
                        4'b0111: dec_op = OP_AND;
                        4'b0110: dec_op = OP_OR;
                        4'b0001: dec_op = OP_SLL;
                        default: dec_ill = 1'b1;
                    endcase
                end else begin
                    case (Funct[2:0])
                        3'b000: dec_op = OP_MUL;
`ifdef ALU_SEQ_DIV_EN
                        3'b101: dec_op = OP_DIVU;
                        3'b111: dec_op = OP_REMU;
`else
                        // Divide not built: flag and return zero instead of ADD.
                        3'b101, 3'b111: begin
                            dec_ill = 1'b1;
                            dec_clr = 1'b1;
                        end
`endif
                        default: dec_ill = 1'b1;
                    endcase
                end
            end
            default: dec_ill = 1'b1;
        endcase
    end

    // Single-cycle result, captured into acc on accept
    always_comb begin
        case (dec_op)
            OP_SUB:  alu_val = a - b;
            OP_AND:  alu_val = a & b;
            OP_OR:   alu_val = a | b;
            OP_SLL:  alu_val = a << b[SHW-1:0];
            default: alu_val = a + b;
        endcase
        if (dec_clr) begin
            alu_val = '0;
        end
    end

`ifdef ALU_SEQ_DIV_EN
    // One restoring-divide step; the extra top bit catches the shifted-out
    // remainder bit so the trial subtraction never loses information.
    logic [WIDTH:0] div_sh;
    logic [WIDTH:0] div_diff;
    assign div_sh   = {acc_q, mplier_q[WIDTH-1]};
    assign div_diff = div_sh - {1'b0, mcand_q};
    // Quotient ends up in mplier; divide-by-zero also parks all-ones there.
    assign fin_val  = (op_q == OP_DIVU) ? mplier_q : acc_q;
`else
    assign fin_val  = acc_q;
`endif

    // ---------------- next state ----------------
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        ill_pend_d = ill_pend_q;
        done_d     = 1'b0;
        result_d   = result_q;
        zero_d     = zero_q;
        illegal_d  = illegal_q;
        acc_d      = acc_q;
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        cnt_d      = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d       = dec_op;
                    ill_pend_d = dec_ill;
                    acc_d      = alu_val;
                    state_d    = S_FIN;
                    if (dec_op == OP_MUL) begin
                        acc_d    = '0;
                        mcand_d  = a;
                        mplier_d = b;
                        cnt_d    = (SHW+1)'(WIDTH);
                        state_d  = S_MUL;
                    end
`ifdef ALU_SEQ_DIV_EN
                    if (dec_op == OP_DIVU || dec_op == OP_REMU) begin
                        if (b == '0) begin
                            // REMU reads acc (= a), DIVU reads mplier (= all-ones)
                            acc_d    = a;
                            mplier_d = '1;
                        end else begin
                            acc_d    = '0;
                            mcand_d  = b;
                            mplier_d = a;
                            cnt_d    = (SHW+1)'(WIDTH);
                            state_d  = S_DIV;
                        end
                    end
`endif
                end
            end
            S_MUL: begin
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q - 1'b1;
                if (cnt_q == (SHW+1)'(1)) begin
                    state_d = S_FIN;
                end
            end
`ifdef ALU_SEQ_DIV_EN
            S_DIV: begin
                if (!div_diff[WIDTH]) begin
                    acc_d    = div_diff[WIDTH-1:0];
                    mplier_d = {mplier_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_d    = div_sh[WIDTH-1:0];
                    mplier_d = {mplier_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == (SHW+1)'(1)) begin
                    state_d = S_FIN;
                end
            end
`endif
            S_FIN: begin
                done_d    = 1'b1;
                result_d  = fin_val;
                zero_d    = (fin_val == '0);
                illegal_d = ill_pend_q;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- registers ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            op_q       <= OP_ADD;
            ill_pend_q <= 1'b0;
            done_q     <= 1'b0;
            result_q   <= '0;
            zero_q     <= 1'b1;
            illegal_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            ill_pend_q <= ill_pend_d;
            done_q     <= done_d;
            result_q   <= result_d;
            zero_q     <= zero_d;
            illegal_q  <= illegal_d;
        end
    end

    always_ff @(posedge clk) begin
        acc_q    <= acc_d;
        mcand_q  <= mcand_d;
        mplier_q <= mplier_d;
        cnt_q    <= cnt_d;
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign result    = result_q;
    assign zero      = zero_q;
    assign illegal   = illegal_q;
    assign Operation = op_q;

endmodule
